// File: rtl/fc_out_sequencer_pkg.sv
// Shared types and defaults for the output fully-connected layer sequencer.
// Holds the FSM state encoding, layer-size defaults and the counter-width helper.
package fc_pkg;

  localparam int DEF_N_OUT  = 10;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_PU_LAT = 3;
  localparam int CLASS_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    SCAN,
    OUT
  } state_e;

  // The shared phase counter must index every phase and still slice into
  // both the address and the class index fields.
  function automatic int cnt_width(int n_in, int n_out, int pu_lat, int addr_w);
    int m;
    int w;
    m = n_in;
    if (n_out > m) m = n_out;
    if (pu_lat > m) m = pu_lat;
    w = $clog2(m);
    if (w < addr_w) w = addr_w;
    if (w < CLASS_W) w = CLASS_W;
    return w;
  endfunction

endpackage

// File: rtl/fc_out_sequencer_if.sv
// Bus between the sequencer, the MAC processing unit / memories and the result consumer.
// The master modport is the sequencer side; slave is the environment side.
interface fc_out_sequencer_if
  import fc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int ACC_W  = DEF_ACC_W
);

  logic                      rd_en_o;
  logic [ADDR_W-1:0]         in_addr_o;
  logic [ADDR_W-1:0]         w_addr_o;
  logic                      pu_en_o;
  logic                      pu_clear_o;
  logic [ACC_W*N_OUT-1:0]    pu_data_i;
  logic [CLASS_W-1:0]        class_o;
  logic signed [ACC_W-1:0]   max_o;
  logic                      class_valid_o;
  logic                      class_ready_i;
  logic                      done_o;

  modport master (
    output rd_en_o, in_addr_o, w_addr_o, pu_en_o, pu_clear_o,
    output class_o, max_o, class_valid_o, done_o,
    input  pu_data_i, class_ready_i
  );

  modport slave (
    input  rd_en_o, in_addr_o, w_addr_o, pu_en_o, pu_clear_o,
    input  class_o, max_o, class_valid_o, done_o,
    output pu_data_i, class_ready_i
  );

endinterface

// File: rtl/fc_out_sequencer_serial_argmax.sv
// Serial signed argmax: one accumulator per cycle, strict greater-than so ties keep the lowest index.
// The *_next outputs carry the post-step value so the caller can capture the final result on the last step.
module serial_argmax
  import fc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clear_i,
  input  logic                    step_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [CLASS_W-1:0]      idx_i,
  output logic signed [ACC_W-1:0] best_next_o,
  output logic [CLASS_W-1:0]      idx_next_o
);

  logic signed [ACC_W-1:0] best_q, best_d;
  logic [CLASS_W-1:0]      idx_q, idx_d;

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    if (clear_i) begin
      best_d = acc_i;
      idx_d  = '0;
    end else if (step_i && (acc_i > best_q)) begin
      best_d = acc_i;
      idx_d  = idx_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

  assign best_next_o = best_d;
  assign idx_next_o  = idx_d;

endmodule

// File: rtl/fc_out_sequencer.sv
// Per-image sequencer for the 10-neuron output layer: clear, feed N_IN rows, drain the PU,
// scan the accumulators for the argmax and hand the class over on a valid/ready handshake.
module fc_out_sequencer
  import fc_pkg::*;
#(
  parameter int N_IN   = 64,
  parameter int ADDR_W = 6,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PU_LAT = DEF_PU_LAT
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                start_i,
  output logic                busy_o,
  fc_out_sequencer_if.master  bus
);

  localparam int CNT_W = cnt_width(N_IN, N_OUT, PU_LAT, ADDR_W);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PU_LAT - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(N_OUT - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    clear_q, clear_d;
  logic                    feed_q, feed_d;
  logic                    valid_q, valid_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CLASS_W-1:0]      class_q, class_d;
  logic signed [ACC_W-1:0] max_q, max_d;

  logic signed [ACC_W-1:0] acc_arr [N_OUT];
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [ACC_W-1:0] best_next;
  logic [CLASS_W-1:0]      idx_next;
  logic                    handshake;

  for (genvar i = 0; i < N_OUT; i++) begin : g_acc
    assign acc_arr[i] = bus.pu_data_i[i*ACC_W +: ACC_W];
  end

  assign acc_sel   = acc_arr[cnt_q[CLASS_W-1:0]];
  assign handshake = valid_q & bus.class_ready_i;

  serial_argmax #(.ACC_W(ACC_W)) u_argmax (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clear_i     ((state_q == SCAN) && (cnt_q == '0)),
    .step_i      (state_q == SCAN),
    .acc_i       (acc_sel),
    .idx_i       (cnt_q[CLASS_W-1:0]),
    .best_next_o (best_next),
    .idx_next_o  (idx_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    class_d = class_q;
    max_d   = max_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: if (cnt_q == FEED_LAST) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      DRAIN: if (cnt_q == DRAIN_LAST) begin
        state_d = SCAN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      SCAN: if (cnt_q == SCAN_LAST) begin
        state_d = OUT;
        cnt_d   = '0;
        class_d = idx_next;
        max_d   = best_next;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      OUT: if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the upcoming state so they leave a flop in step with it.
    busy_d  = (state_d != IDLE);
    clear_d = (state_d == CLEAR);
    feed_d  = (state_d == FEED);
    valid_d = (state_d == OUT);
    addr_d  = feed_d ? cnt_d[ADDR_W-1:0] : '0;
  end

  // NOTE: the synchronous reset clears every flop here, including the result
  // registers, so an aborted image can never leave a stale class visible.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      feed_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      class_q <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
      feed_q  <= feed_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      class_q <= class_d;
      max_q   <= max_d;
    end
  end

  assign busy_o            = busy_q;
  assign bus.rd_en_o       = feed_q;
  assign bus.pu_en_o       = feed_q;
  assign bus.in_addr_o     = addr_q;
  assign bus.w_addr_o      = addr_q;
  assign bus.pu_clear_o    = clear_q;
  assign bus.class_o       = class_q;
  assign bus.max_o         = max_q;
  assign bus.class_valid_o = valid_q;
  // done marks the accepting cycle itself, so it is the AND of the registered valid and ready.
  assign bus.done_o        = handshake;

endmodule
